// File: rtl/name_stream_feeder.sv
// name_stream_feeder
// ------------------
// A programmable source of name components for the FIB lookup pipeline. It
// holds a table of up to NUM_NAMES names. Each name is a list of up to
// MAX_NAME_LENGTH components of WORD_SIZE bits. On start, it streams the first
// start_count table slots component by component, using valid/ready handshaking.
// After every accepted component it inserts GAP_CYCLES idle cycles.
//
// Ports
//   clk_in, reset            rising-edge clock, asynchronous active-high reset
//   load_en / load_name_idx / load_word_idx / load_data
//                            component write port (ignored while busy)
//   load_len_en / load_len   name length write port (clamped to MAX_NAME_LENGTH)
//   start / start_count      launch a stream over slots 0..start_count-1
//   component_ready          downstream accepts the current component
//   name_component, component_valid, last_component, name_index
//                            registered stream outputs
//   busy, done, names_sent   status: not idle, end-of-stream pulse, names finished
module name_stream_feeder #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int NUM_NAMES       = 8,
  parameter int NAME_INDEX_SIZE = 3,
  parameter int WORD_INDEX_SIZE = 3,
  parameter int LEN_SIZE        = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [NAME_INDEX_SIZE-1:0] load_name_idx,
  input  logic [WORD_INDEX_SIZE-1:0] load_word_idx,
  input  logic [WORD_SIZE-1:0]       load_data,
  input  logic                       load_len_en,
  input  logic [LEN_SIZE-1:0]        load_len,
  input  logic                       start,
  input  logic [NAME_INDEX_SIZE:0]   start_count,
  input  logic                       component_ready,
  output logic [WORD_SIZE-1:0]       name_component,
  output logic                       component_valid,
  output logic                       last_component,
  output logic [NAME_INDEX_SIZE-1:0] name_index,
  output logic                       busy,
  output logic                       done,
  output logic [NAME_INDEX_SIZE:0]   names_sent
);

  localparam logic [LEN_SIZE-1:0]        LEN_MAX  = LEN_SIZE'(MAX_NAME_LENGTH);
  localparam logic [NAME_INDEX_SIZE:0]   NUM_C    = (NAME_INDEX_SIZE+1)'(NUM_NAMES);
  localparam logic [3:0]                 GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int                         MEM_DEPTH = 1 << (NAME_INDEX_SIZE + WORD_INDEX_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EMIT, S_GAP, S_DONE} state_t;

  state_t                     state_q;
  logic [NAME_INDEX_SIZE:0]   count_q;
  logic [NAME_INDEX_SIZE:0]   name_ptr_q;
  logic [WORD_INDEX_SIZE-1:0] word_ptr_q;
  logic [3:0]                 gap_cnt_q;
  logic                       after_final_q;  // the component before this gap ended its name
  logic [WORD_SIZE-1:0]       comp_q;
  logic                       valid_q;
  logic                       last_q;
  logic [NAME_INDEX_SIZE-1:0] name_index_q;
  logic                       done_q;
  logic [NAME_INDEX_SIZE:0]   names_sent_q;

  logic [WORD_SIZE-1:0] word_mem [0:MEM_DEPTH-1];
  logic [LEN_SIZE-1:0]  len_mem  [0:NUM_NAMES-1];

  logic                       idle;
  logic [NAME_INDEX_SIZE-1:0] cur_slot;
  logic [LEN_SIZE-1:0]        cur_len;
  logic [WORD_INDEX_SIZE-1:0] word_ptr_inc;
  logic [WORD_INDEX_SIZE-1:0] rd_word_idx;
  logic [WORD_SIZE-1:0]       rd_data;
  logic                       rd_is_last;
  logic [LEN_SIZE-1:0]        len_clamped;

  assign idle        = (state_q == S_IDLE);
  // The low bits are only used as a table index once name_ptr < count <= NUM_NAMES.
  assign cur_slot    = name_ptr_q[NAME_INDEX_SIZE-1:0];
  assign cur_len     = len_mem[cur_slot];
  assign word_ptr_inc = word_ptr_q + 1'b1;
  assign len_clamped = (load_len > LEN_MAX) ? LEN_MAX : load_len;

  // One shared read port. It points at the component the FSM loads into the
  // output register on this edge: the first word when leaving CHECK, the next
  // word when chaining EMIT->EMIT, and the current pointer when leaving GAP.
  always_comb begin
    rd_word_idx = word_ptr_q;
    case (state_q)
      S_CHECK: rd_word_idx = '0;
      S_EMIT:  rd_word_idx = word_ptr_inc;
      default: rd_word_idx = word_ptr_q;
    endcase
  end

  assign rd_data    = word_mem[{cur_slot, rd_word_idx}];
  assign rd_is_last = ((LEN_SIZE'(rd_word_idx) + LEN_SIZE'(1)) == cur_len);

  // The component table is deliberately left out of reset.
  always_ff @(posedge clk_in) begin
    if (load_en && idle) begin
      word_mem[{load_name_idx, load_word_idx}] <= load_data;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NAMES; i++) begin
        len_mem[i] <= '0;
      end
    end else if (load_len_en && idle) begin
      len_mem[load_name_idx] <= len_clamped;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      name_ptr_q    <= '0;
      word_ptr_q    <= '0;
      gap_cnt_q     <= '0;
      after_final_q <= 1'b0;
      comp_q        <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      name_index_q  <= '0;
      done_q        <= 1'b0;
      names_sent_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q      <= (start_count > NUM_C) ? NUM_C : start_count;
            name_ptr_q   <= '0;
            names_sent_q <= '0;
            state_q      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (name_ptr_q == count_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cur_len == '0) begin
            name_ptr_q <= name_ptr_q + 1'b1;
          end else begin
            word_ptr_q   <= '0;
            comp_q       <= rd_data;
            last_q       <= rd_is_last;
            name_index_q <= cur_slot;
            valid_q      <= 1'b1;
            state_q      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (component_ready) begin
            after_final_q <= last_q;
            if (last_q) begin
              name_ptr_q   <= name_ptr_q + 1'b1;
              names_sent_q <= names_sent_q + 1'b1;
            end else begin
              word_ptr_q <= word_ptr_inc;
            end
            if (GAP_CYCLES > 0) begin
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
              gap_cnt_q <= GAP_LAST;
              state_q   <= S_GAP;
            end else if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= S_CHECK;
            end else begin
              comp_q  <= rd_data;
              last_q  <= rd_is_last;
              valid_q <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            if (after_final_q) begin
              state_q <= S_CHECK;
            end else begin
              comp_q  <= rd_data;
              last_q  <= rd_is_last;
              valid_q <= 1'b1;
              state_q <= S_EMIT;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign name_component  = comp_q;
  assign component_valid = valid_q;
  assign last_component  = last_q;
  assign name_index      = name_index_q;
  assign busy            = !idle;
  assign done            = done_q;
  assign names_sent      = names_sent_q;

endmodule

// File: tb/tb_name_stream_feeder.sv
module tb_name_stream_feeder;
  localparam int WS = 32, ML = 8, NN = 8, NI = 3, WI = 3, LS = 4, GAP = 1;
  localparam int MAXC = 2000;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [NI-1:0] load_name_idx = '0;
  logic [WI-1:0] load_word_idx = '0;
  logic [WS-1:0] load_data = '0;
  logic          load_len_en = 1'b0;
  logic [LS-1:0] load_len = '0;
  logic          start = 1'b0;
  logic [NI:0]   start_count = '0;
  logic          component_ready = 1'b0;
  logic [WS-1:0] name_component;
  logic          component_valid;
  logic          last_component;
  logic [NI-1:0] name_index;
  logic          busy;
  logic          done;
  logic [NI:0]   names_sent;

  name_stream_feeder #(
    .WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .NUM_NAMES(NN), .NAME_INDEX_SIZE(NI),
    .WORD_INDEX_SIZE(WI), .LEN_SIZE(LS), .GAP_CYCLES(GAP)
  ) dut (
    .clk_in(clk_in), .reset(reset), .load_en(load_en), .load_name_idx(load_name_idx),
    .load_word_idx(load_word_idx), .load_data(load_data), .load_len_en(load_len_en),
    .load_len(load_len), .start(start), .start_count(start_count),
    .component_ready(component_ready), .name_component(name_component),
    .component_valid(component_valid), .last_component(last_component),
    .name_index(name_index), .busy(busy), .done(done), .names_sent(names_sent)
  );

  always #5 clk_in = ~clk_in;

  // Reference table: what the DUT should hold
  logic [WS-1:0] m_word [NN][ML];
  int            m_len  [NN];

  int tests = 0;
  int fails = 0;

  // Per-run observations
  logic [WS-1:0] acc_data [$];
  int            acc_idx  [$];
  bit            acc_last [$];
  bit            v_at [64];
  logic [WS-1:0] d_at [64];
  bit            l_at [64];
  int done_cycle, valid_cycles, ns_at_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_word(input int s, input int w, input logic [WS-1:0] d);
    load_en = 1'b1; load_name_idx = NI'(s); load_word_idx = WI'(w); load_data = d;
    tick();
    load_en = 1'b0;
    m_word[s][w] = d;
  endtask

  task automatic load_length(input int s, input int l);
    load_len_en = 1'b1; load_name_idx = NI'(s); load_len = LS'(l);
    tick();
    load_len_en = 1'b0;
    m_len[s] = (l > ML) ? ML : l;
  endtask

  task automatic fill_random_words();
    for (int s = 0; s < NN; s++)
      for (int w = 0; w < ML; w++)
        load_word(s, w, $urandom());
  endtask

  // Streams cnt names; rmode 0: always ready, 1: not ready in cycles rlo..rhi,
  // 2: random ready. At cycle 'inject' the load ports and start are pulsed.
  task automatic run_stream(input int cnt, input int rmode, input int rlo, input int rhi,
                            input int inject);
    int ccount, k, exp_ns;
    bit r, prev_v, prev_r, prev_l;
    logic [WS-1:0] prev_d;
    int prev_i;
    acc_data.delete(); acc_idx.delete(); acc_last.delete();
    for (int i = 0; i < 64; i++) begin v_at[i] = 0; d_at[i] = '0; l_at[i] = 0; end
    done_cycle = -1; valid_cycles = 0; ns_at_done = 0;
    prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0; prev_i = 0;
    start_count = (NI+1)'(cnt);
    start = 1'b1;
    tick();  // edge 0 samples start
    start = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      case (rmode)
        0: r = 1'b1;
        1: r = !(c >= rlo && c <= rhi);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      component_ready = r;
      if (prev_v && !prev_r) begin
        check("hold_valid", 64'(component_valid), 64'(1));
        check("hold_data", 64'(name_component), 64'(prev_d));
        check("hold_index", 64'(name_index), 64'(prev_i));
        check("hold_last", 64'(last_component), 64'(prev_l));
      end
      if (c < 64) begin
        v_at[c] = component_valid; d_at[c] = name_component; l_at[c] = last_component;
      end
      if (component_valid) begin
        valid_cycles++;
        if (r) begin
          acc_data.push_back(name_component);
          acc_idx.push_back(int'(name_index));
          acc_last.push_back(last_component);
        end
      end
      if (done_cycle >= 0) begin
        // start was held high during the DONE cycle and must have been ignored
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_after_done", 64'(busy), 64'(0));
        start = 1'b0;
        break;
      end
      if (done) begin
        done_cycle = c;
        ns_at_done = int'(names_sent);
        start = 1'b1;
      end
      if (c == inject) begin
        load_en = 1'b1; load_name_idx = '0; load_word_idx = '0; load_data = ~m_word[0][0];
        load_len_en = 1'b1; load_len = '0; start = 1'b1;
      end else if (c == inject + 1) begin
        load_en = 1'b0; load_len_en = 1'b0; start = 1'b0;
      end
      prev_v = component_valid; prev_r = r; prev_d = name_component;
      prev_i = int'(name_index); prev_l = last_component;
      tick();
    end
    check("done_seen", 64'(done_cycle >= 0), 64'(1));
    ccount = (cnt > NN) ? NN : cnt;
    k = 0; exp_ns = 0;
    for (int s = 0; s < ccount; s++) begin
      if (m_len[s] > 0) exp_ns++;
      for (int w = 0; w < m_len[s]; w++) begin
        if (k < acc_data.size()) begin
          check("comp_data", 64'(acc_data[k]), 64'(m_word[s][w]));
          check("comp_index", 64'(acc_idx[k]), 64'(s));
          check("comp_last", 64'(acc_last[k]), 64'(w == m_len[s] - 1));
        end
        k++;
      end
    end
    check("num_components", 64'(acc_data.size()), 64'(k));
    check("names_sent", 64'(ns_at_done), 64'(exp_ns));
    // one CHECK per scanned slot plus the final one, every EMIT cycle, GAP per component
    check("done_cycle", 64'(done_cycle), 64'(2 + ccount + valid_cycles + k * GAP));
    $display("[TB] stream cnt=%0d: %0d components, done at cycle %0d", cnt,
             acc_data.size(), done_cycle);
  endtask

  initial begin
    int found;
    for (int s = 0; s < NN; s++) begin
      m_len[s] = 0;
      for (int w = 0; w < ML; w++) m_word[s][w] = '0;
    end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_valid", 64'(component_valid), 64'(0));
    check("rst_data", 64'(name_component), 64'(0));
    check("rst_last", 64'(last_component), 64'(0));
    check("rst_index", 64'(name_index), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sent", 64'(names_sent), 64'(0));

    // Basic two-component name with GAP=1
    fill_random_words();
    load_word(0, 0, 32'hA0A0A0A0);
    load_word(0, 1, 32'hB1B1B1B1);
    load_length(0, 2);
    run_stream(1, 0, 0, 0, -1);
    check("t1_v2", 64'(v_at[2]), 64'(1));
    check("t1_d2", 64'(d_at[2]), 64'(32'hA0A0A0A0));
    check("t1_l2", 64'(l_at[2]), 64'(0));
    check("t1_v3", 64'(v_at[3]), 64'(0));
    check("t1_v4", 64'(v_at[4]), 64'(1));
    check("t1_d4", 64'(d_at[4]), 64'(32'hB1B1B1B1));
    check("t1_l4", 64'(l_at[4]), 64'(1));
    check("t1_done7", 64'(done_cycle), 64'(7));

    // Backpressure: not ready in cycles 2..5
    run_stream(1, 1, 2, 5, -1);
    for (int c = 2; c <= 6; c++) begin
      check("bp_valid", 64'(v_at[c]), 64'(1));
      check("bp_data", 64'(d_at[c]), 64'(32'hA0A0A0A0));
    end
    check("bp_gap7", 64'(v_at[7]), 64'(0));
    check("bp_v8", 64'(v_at[8]), 64'(1));
    check("bp_d8", 64'(d_at[8]), 64'(32'hB1B1B1B1));

    // Empty-name skipping
    load_length(0, 0); load_length(1, 3); load_length(2, 0); load_length(3, 1);
    run_stream(4, 0, 0, 0, -1);
    if (acc_idx.size() == 4) begin
      check("skip_idx0", 64'(acc_idx[0]), 64'(1));
      check("skip_idx3", 64'(acc_idx[3]), 64'(3));
      check("skip_last1", 64'(acc_last[1]), 64'(0));
      check("skip_last2", 64'(acc_last[2]), 64'(1));
      check("skip_last3", 64'(acc_last[3]), 64'(1));
    end
    check("skip_count", 64'(acc_idx.size()), 64'(4));
    check("skip_sent", 64'(ns_at_done), 64'(2));

    // Length clamp, empty stream, oversized start_count
    load_length(0, 15);
    run_stream(1, 0, 0, 0, -1);
    check("clamp_count", 64'(acc_data.size()), 64'(8));
    check("clamp_last_is_8th", 64'(acc_last.size() == 8 && acc_last[7]), 64'(1));
    run_stream(0, 0, 0, 0, -1);
    check("zero_no_valid", 64'(valid_cycles), 64'(0));
    check("zero_done2", 64'(done_cycle), 64'(2));
    for (int s = 0; s < NN; s++) load_length(s, $urandom_range(1, 10));
    run_stream(9, 2, 0, 0, -1);

    // Randomized streams
    for (int it = 0; it < 6; it++) begin
      fill_random_words();
      for (int s = 0; s < NN; s++) load_length(s, $urandom_range(0, 10));
      run_stream($urandom_range(0, 9), 2, 0, 0, -1);
    end

    // Controls while busy are ignored; replay is identical
    load_length(0, 5);
    run_stream(8, 2, 0, 0, 3);
    run_stream(8, 0, 0, 0, -1);

    // Asynchronous reset during name 1
    fill_random_words();
    for (int s = 0; s < NN; s++) load_length(s, (s < 2) ? 3 + s : 0);
    start_count = 2; start = 1'b1; component_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (component_valid && name_index == 1) found = 1;
      else tick();
    end
    check("reached_name1", 64'(found), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(component_valid), 64'(0));
    check("arst_data", 64'(name_component), 64'(0));
    check("arst_index", 64'(name_index), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_sent", 64'(names_sent), 64'(0));
    for (int s = 0; s < NN; s++) m_len[s] = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      check("arst_no_done", 64'(done), 64'(0));
      check("arst_idle", 64'(busy), 64'(0));
      tick();
    end
    run_stream(2, 0, 0, 0, -1);  // lengths cleared: nothing to send
    load_length(0, 3); load_length(1, 4);
    run_stream(2, 2, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
